// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with the architectural NZVC flag register.
// Also provides a zero-cycle flag bypass and B.cond evaluation for EX.
module ex_mem_stage_reg #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_negative,
  input  logic              ex_zero,
  input  logic              ex_overflow,
  input  logic              ex_carry,
  input  logic              ex_set_flags,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_to_reg,
  input  logic [3:0]        ex_cond,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_write,
  output logic              mem_mem_read,
  output logic              mem_mem_to_reg,
  output logic [3:0]        flags_q,
  output logic [3:0]        flags_fwd,
  output logic              cond_true
);

  localparam logic [REG_W-1:0] XZR = '1;

  logic [3:0] alu_flags;
  logic       flag_wr;
  logic       n, z, v, c;

  assign alu_flags = {ex_negative, ex_zero, ex_overflow, ex_carry};
  assign flag_wr   = ex_valid & ex_set_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      flags_q        <= 4'b0000;
    end else if (flush) begin
      // Bubble: flags are left untouched on a flush.
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_reg_write  <= ex_valid & ex_reg_write & (ex_rd != XZR);
      mem_mem_write  <= ex_valid & ex_mem_write;
      mem_mem_read   <= ex_valid & ex_mem_read;
      mem_mem_to_reg <= ex_valid & ex_mem_to_reg;
      if (flag_wr)
        flags_q <= alu_flags;
    end
  end

  // ADDS/SUBS in EX bypass their flags straight to B.cond.
  assign flags_fwd = (flag_wr & ~flush) ? alu_flags : flags_q;
  assign {n, z, v, c} = flags_fwd;

  always_comb begin
    cond_true = 1'b1;
    unique case (ex_cond)
      4'd0:  cond_true = z;
      4'd1:  cond_true = ~z;
      4'd2:  cond_true = c;
      4'd3:  cond_true = ~c;
      4'd4:  cond_true = n;
      4'd5:  cond_true = ~n;
      4'd6:  cond_true = v;
      4'd7:  cond_true = ~v;
      4'd8:  cond_true = c & ~z;
      4'd9:  cond_true = ~(c & ~z);
      4'd10: cond_true = (n == v);
      4'd11: cond_true = (n != v);
      4'd12: cond_true = ~z & (n == v);
      4'd13: cond_true = ~(~z & (n == v));
      4'd14: cond_true = 1'b1;
      4'd15: cond_true = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg: directed cases then random.
// Expected state comes from a behavioural model; a monitor compares.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_valid;
  logic [63:0] ex_result, ex_store_data;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry;
  logic        ex_set_flags;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg;
  logic [3:0]  ex_cond;
  logic        mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg;
  logic [3:0]  flags_q, flags_fwd;
  logic        cond_true;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_negative(ex_negative), .ex_zero(ex_zero),
    .ex_overflow(ex_overflow), .ex_carry(ex_carry),
    .ex_set_flags(ex_set_flags), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_cond(ex_cond),
    .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_mem_read(mem_mem_read), .mem_mem_to_reg(mem_mem_to_reg),
    .flags_q(flags_q), .flags_fwd(flags_fwd), .cond_true(cond_true)
  );

  typedef struct packed {
    logic        v;
    logic [63:0] res;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw, mw, mr, m2r;
    logic [3:0]  fl;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   known = 0;
  int   checks = 0;
  int   errors = 0;

  // Architectural B.cond: base test from cond[3:1], cond[0] inverts.
  function automatic logic ref_cond(input logic [3:0] cc,
                                    input logic [3:0] f);
    logic fn, fz, fv, fc, b;
    {fn, fz, fv, fc} = f;
    case (cc[3:1])
      3'd0: b = fz;
      3'd1: b = fc;
      3'd2: b = fn;
      3'd3: b = fv;
      3'd4: b = fc && !fz;
      3'd5: b = (fn == fv);
      3'd6: b = !fz && (fn == fv);
      default: b = 1'b1;
    endcase
    if (cc == 4'd15) return 1'b1;
    return cc[0] ? !b : b;
  endfunction

  task automatic idle();
    reset = 0; stall = 0; flush = 0;
    ex_valid = 0; ex_result = '0; ex_store_data = '0;
    {ex_negative, ex_zero, ex_overflow, ex_carry} = 4'b0000;
    ex_set_flags = 0; ex_rd = '0;
    {ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg} = 4'b0000;
    ex_cond = 4'd14;
  endtask

  task automatic set_alu(input logic [3:0] f);
    {ex_negative, ex_zero, ex_overflow, ex_carry} = f;
  endtask

  // Inputs are already driven; check combinational outputs, model the edge.
  task automatic step();
    logic [3:0] alu, fwd;
    logic       ec;
    exp_t       nx;
    alu = {ex_negative, ex_zero, ex_overflow, ex_carry};
    #1;
    if (known) begin
      fwd = (ex_valid && ex_set_flags && !flush) ? alu : cur.fl;
      ec  = ref_cond(ex_cond, fwd);
      checks++;
      if (flags_fwd !== fwd) begin
        errors++;
        $display("FAIL flags_fwd got %b exp %b", flags_fwd, fwd);
      end
      checks++;
      if (cond_true !== ec) begin
        errors++;
        $display("FAIL cond_true cond=%0d got %b exp %b",
                 ex_cond, cond_true, ec);
      end
    end
    nx = cur;
    if (reset) begin
      nx = '0;
    end else if (flush) begin
      nx.v = 0; nx.res = '0; nx.sd = '0; nx.rd = '0;
      nx.rw = 0; nx.mw = 0; nx.mr = 0; nx.m2r = 0;
    end else if (!stall) begin
      nx.v   = ex_valid;
      nx.res = ex_result;
      nx.sd  = ex_store_data;
      nx.rd  = ex_rd;
      nx.rw  = ex_valid && ex_reg_write && (ex_rd != 5'd31);
      nx.mw  = ex_valid && ex_mem_write;
      nx.mr  = ex_valid && ex_mem_read;
      nx.m2r = ex_valid && ex_mem_to_reg;
      if (ex_valid && ex_set_flags) nx.fl = alu;
    end
    if (reset) known = 1;
    if (known) begin
      cur = nx;
      q.push_back(nx);
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: registered outputs are compared one step after each edge.
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      g = {mem_valid, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_write, mem_mem_read,
           mem_mem_to_reg, flags_q};
      checks++;
      if (g[$bits(exp_t)-1:4] !== e[$bits(exp_t)-1:4]) begin
        errors++;
        $display("FAIL mem_regs got %h exp %h",
                 g[$bits(exp_t)-1:4], e[$bits(exp_t)-1:4]);
      end
      checks++;
      if (g.fl !== e.fl) begin
        errors++;
        $display("FAIL flags_q got %b exp %b", g.fl, e.fl);
      end
    end
  end

  initial begin
    idle();
    // Reset with every EX input high.
    reset = 1; stall = 1; flush = 1;
    ex_valid = 1; ex_result = '1; ex_store_data = '1;
    set_alu(4'b1111); ex_set_flags = 1; ex_rd = '1;
    {ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg} = 4'b1111;
    ex_cond = 4'd15;
    @(posedge clk); #2;
    step();
    step();
    idle(); ex_cond = 4'd14; step();
    idle(); ex_cond = 4'd0;  step();
    // Plain capture.
    idle(); ex_valid = 1; ex_result = 64'h0000_0000_DEAD_BEEF;
    ex_rd = 5'd5; ex_reg_write = 1; step();
    // SUBS with Z then B.NE.
    idle(); ex_valid = 1; set_alu(4'b0100); ex_set_flags = 1;
    ex_cond = 4'd0; step();
    idle(); ex_valid = 1; ex_cond = 4'd1; step();
    // Stall holds A while B waits with set_flags.
    idle(); ex_valid = 1; ex_result = 64'hAAAA; step();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; ex_valid = 1; ex_result = 64'hBBBB;
      set_alu(4'b1001); ex_set_flags = 1; step();
    end
    idle(); ex_valid = 1; ex_result = 64'hBBBB;
    set_alu(4'b1001); ex_set_flags = 1; step();
    // Flush beats stall.
    idle(); flush = 1; stall = 1; ex_valid = 1; ex_reg_write = 1;
    ex_mem_read = 1; set_alu(4'b0110); ex_set_flags = 1; step();
    // XZR suppression.
    idle(); ex_valid = 1; ex_rd = 5'd31; ex_reg_write = 1; step();
    // Signed conditions: N=1,V=0 then N=1,V=1,Z=0.
    for (int cc = 10; cc < 14; cc++) begin
      idle(); ex_valid = 1; set_alu(4'b1000); ex_set_flags = 1;
      ex_cond = 4'(cc); step();
    end
    idle(); ex_valid = 1; set_alu(4'b1010); ex_set_flags = 1;
    ex_cond = 4'd12; step();
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_result = {$urandom(), $urandom()};
      ex_store_data = {$urandom(), $urandom()};
      set_alu(4'($urandom()));
      ex_set_flags = $urandom_range(0, 1);
      ex_rd = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom());
      {ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg} =
        4'($urandom());
      ex_cond = 4'($urandom());
      step();
    end
    idle();
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_reg.md
Name: ex_mem_stage_reg

Overview:
- EX/MEM pipeline register of the 5-stage 64-bit CPU.
- Sits directly downstream of the 64-bit ALU and captures its result and its negative/zero/overflow/carry flags each cycle.
- Holds the architectural NZVC flag register, which is updated only by flag-setting instructions (ADDS/SUBS).
- Supplies forwarded flags and a condition-true signal for B.cond, plus registered outputs feeding the MEM stage.

Parameters:
- DATA_W, 64, datapath width; must match the ALU width.
- REG_W, 5, register-number width; register 31 is XZR.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all stage registers and the flag register.
- flush  input  1  replace the captured instruction with a bubble.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_result  input  DATA_W  ALU result.
- ex_negative, ex_zero, ex_overflow, ex_carry  input  1 each  ALU flags.
- ex_set_flags  input  1  instruction writes NZVC.
- ex_store_data  input  DATA_W  data for STUR.
- ex_rd  input  REG_W  destination register.
- ex_reg_write, ex_mem_write, ex_mem_read, ex_mem_to_reg  input  1 each  control bits.
- ex_cond  input  4  B.cond code (EQ=0, NE=1, HS=2, LO=3, MI=4, PL=5, VS=6, VC=7, HI=8, LS=9, GE=10, LT=11, GT=12, LE=13, AL=14/15).
- mem_valid  output  1  registered valid.
- mem_result  output  DATA_W  registered ALU result.
- mem_store_data  output  DATA_W  registered store data.
- mem_rd  output  REG_W  registered destination register.
- mem_reg_write, mem_mem_write, mem_mem_read, mem_mem_to_reg  output  1 each  registered control bits.
- flags_q  output  4  architectural {N,Z,V,C}.
- flags_fwd  output  4  combinational flags visible to the instruction in EX.
- cond_true  output  1  combinational: ex_cond holds under flags_fwd.

Behaviour:
- Reset (synchronous, highest priority): all mem_* outputs are 0, mem_valid is 0, flags_q is 4'b0000. Reset mid-stall or mid-flush still clears everything.
- Priority per rising edge: reset > flush > stall > normal capture.
- Flush: mem_valid and all four mem_* control bits go to 0. mem_result, mem_store_data and mem_rd are don't-care; the implementation sets them to 0. flags_q is unchanged. Flush overrides a simultaneous stall.
- Stall (no flush): every register, including flags_q, holds its value.
- Normal capture (1-cycle latency): all mem_* take the ex_* values; mem_valid = ex_valid.
- Invalid instruction: if ex_valid=0, all mem control bits are forced to 0.
- XZR suppression: mem_reg_write is forced to 0 when ex_rd==31.
- Flag update: flags_q <= {ex_negative, ex_zero, ex_overflow, ex_carry} only on a normal-capture edge with ex_valid & ex_set_flags.
- flags_fwd = ALU flags when ex_valid & ex_set_flags & ~flush; otherwise flags_fwd = flags_q. Zero-cycle bypass, so an ADDS followed immediately by B.cond needs no stall.
- Condition rules for cond_true, evaluated on flags_fwd:
  - EQ: Z. NE: !Z.
  - HS: C. LO: !C.
  - MI: N. PL: !N.
  - VS: V. VC: !V.
  - HI: C&!Z. LS: !(C&!Z).
  - GE: N==V. LT: N!=V.
  - GT: !Z&(N==V). LE: !(!Z&(N==V)).
  - 14/15: 1.
- No arithmetic inside the block; widths pass straight through unchanged.

Test Plan:
- Reset: drive every ex_* input high, hold reset for 2 edges -> every mem_* output and flags_q read 0; cond_true=1 for cond=14; cond_true=0 for cond=0 (EQ, Z=0).
- Capture: ex_valid=1, ex_result=64'h0000_0000_DEAD_BEEF, ex_rd=5, reg_write=1 -> after 1 edge mem_result=DEAD_BEEF, mem_rd=5, mem_reg_write=1, mem_valid=1; flags_q unchanged because set_flags=0.
- Flags and bypass: SUBS with ex_zero=1, set_flags=1, ex_cond=EQ -> flags_fwd=4'b0100 and cond_true=1 in the same cycle. Next cycle, non-flag instruction with ex_cond=NE -> flags_q=4'b0100, cond_true=0.
- Stall: capture value A, then stall=1 for 3 cycles while ex_result=B and set_flags=1 -> mem_result stays A and flags_q unchanged. Deassert stall -> B captured and flags update.
- Flush beats stall: flush=1 and stall=1 with ex_valid=1, reg_write=1, set_flags=1 -> mem_valid=0, all mem control bits 0, flags_q unchanged, flags_fwd=flags_q.
- XZR and signed conditions: ex_rd=31, reg_write=1 -> mem_reg_write=0. Flags N=1,V=0 -> LT=1, GE=0, GT=0, LE=1. Flags N=1,V=1,Z=0 -> GT=1.
